// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device-generated clock edges and checks the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 3200,
   parameter int TIMEOUT_CYCLES = 60000,
   parameter int CNT_WIDTH      = 16
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam logic [CNT_WIDTH-1:0] INHIBIT_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t                 state;
   logic [9:0]             frame;
   logic [3:0]             bit_cnt;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   clk_p0, clk_p1, clk_p2;
   logic                   dat_p0, dat_p1;
   logic                   fall;
   logic                   timeout;
   logic                   accept;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   // Synchronizer stage: p0/p1 resynchronize the pins, p2 remembers the previous clk level.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         clk_p0 <= 1'b1;
         clk_p1 <= 1'b1;
         clk_p2 <= 1'b1;
         dat_p0 <= 1'b1;
         dat_p1 <= 1'b1;
      end else begin
         clk_p0 <= ps2_clk_in;
         clk_p1 <= clk_p0;
         clk_p2 <= clk_p1;
         dat_p0 <= ps2_dat_in;
         dat_p1 <= dat_p0;
      end
   end

   assign fall    = clk_p2 & ~clk_p1;
   assign timeout = (cnt == TIMEOUT_LAST);
   assign accept  = (state == IDLE) & tx_valid & tx_ready;
   assign tx_busy = ~tx_ready;

   // Frame holds data only, so it is loaded without reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         frame <= {1'b1, odd_parity(tx_data), tx_data};
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         tx_ready   <= 1'b1;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
         bit_cnt    <= 4'd0;
         cnt        <= '0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         case (state)
            IDLE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               tx_ready   <= 1'b1;
               if (accept) begin
                  tx_ready   <= 1'b0;
                  ps2_clk_oe <= 1'b1;
                  bit_cnt    <= 4'd0;
                  cnt        <= '0;
                  state      <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (cnt == INHIBIT_LAST) begin
                  ps2_dat_oe <= 1'b1;
                  state      <= REQ;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            REQ: begin
               ps2_clk_oe <= 1'b0;
               cnt        <= '0;
               state      <= SEND;
            end
            SEND, ACK, WAIT_IDLE: begin
               if (timeout) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  tx_done    <= 1'b1;
                  tx_err     <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (state == SEND) begin
                     if (fall) begin
                        ps2_dat_oe <= ~frame[bit_cnt];
                        bit_cnt    <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) begin
                           state <= ACK;
                        end
                     end
                  end else if (state == ACK) begin
                     // Device acknowledges by holding dat low across this clock pulse.
                     if (fall) begin
                        if (!dat_p1) begin
                           state <= WAIT_IDLE;
                        end else begin
                           ps2_dat_oe <= 1'b0;
                           tx_done    <= 1'b1;
                           tx_err     <= 1'b1;
                           state      <= IDLE;
                        end
                     end
                  end else begin
                     if (clk_p1 && dat_p1) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a simple device model that clocks
// the frame out and answers with (or without) an ACK.
module tb_ps2_host_tx;

   localparam int INH = 8;
   localparam int TMO = 2000;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_busy, tx_done, tx_err;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .tx_err(tx_err),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         parity;
      bit         err;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      bit         err;
      bit         chk;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_checks = 0;
   int         n_fail = 0;
   int         done_count = 0;
   logic [7:0] rx_byte = 8'h00;
   bit         pend_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every completion pops the oldest expected result.
   always @(negedge clk) begin
      if (pend_ready) begin
         check("ready_after_done", {tx_ready, tx_busy}, 2'b10);
         pend_ready = 1'b0;
      end
      if (resetN && tx_err && !tx_done) begin
         check("err_without_done", tx_err, 1'b0);
      end
      if (resetN && tx_done) begin
         done_count++;
         pend_ready = 1'b1;
         check("lines_released_at_done", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
         if (sb.size() == 0) begin
            check("done_with_empty_scoreboard", tx_done, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            check("tx_err", tx_err, mon_e.err);
            if (mon_e.chk) begin
               check("rx_byte", rx_byte, mon_e.data);
            end
         end
      end
   end

   task automatic measure_inhibit();
      int n = 0;
      int highs = 0;
      int pos = -1;
      while (ps2_clk_oe === 1'b1 && n < 100) begin
         if (ps2_dat_oe) begin
            highs++;
            pos = n;
         end
         n++;
         @(negedge clk);
      end
      check("inhibit_len", n, INH + 1);
      check("req_dat_cycles", highs, 1);
      check("req_dat_position", pos, INH);
   endtask

   task automatic start_tx(input logic [7:0] d, input bit hold, input logic [7:0] next_d);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
      tx_data = next_d;
      check("clk_low_after_accept", ps2_clk_oe, 1'b1);
      measure_inhibit();
   endtask

   task automatic device(input bit ack, input int nbits,
                         output logic [9:0] line_bits, output logic [9:0] oe_bits);
      line_bits = '1;
      oe_bits   = '0;
      repeat (5) @(negedge clk);
      check("start_bit_low", ps2_dat_in, 1'b0);
      for (int i = 0; i < nbits; i++) begin
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         line_bits[i] = ps2_dat_in;
         oe_bits[i]   = ps2_dat_oe;
         dev_clk_low = 1'b0;
         repeat (20) @(negedge clk);
      end
      if (nbits == 10) begin
         rx_byte     = line_bits[7:0];
         dev_dat_low = ack;
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (5) @(negedge clk);
         dev_dat_low = 1'b0;
      end
   endtask

   task automatic wait_done(input int base);
      int n = 0;
      while (done_count <= base && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("done_count", done_count, base + 1);
   endtask

   task automatic run_vec(input vec_t v);
      int         base;
      logic [9:0] lb, ob, exp_oe;
      base   = done_count;
      exp_oe = ~{1'b1, v.parity, v.data};
      sb.push_back('{v.data, v.err, 1'b1});
      start_tx(v.data, 1'b0, v.data);
      device(v.ack, 10, lb, ob);
      check("parity_bit", lb[8], v.parity);
      check("stop_bit", lb[9], 1'b1);
      check("dat_oe_pattern", ob, exp_oe);
      wait_done(base);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, test did not end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vecs[4];
      vec_t       vff;
      logic [9:0] lb, ob, exp_oe;
      int         base;
      int         n;

      vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b1};
      vff     = '{8'hFF, 1'b1, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      check("reset_ready_busy", {tx_ready, tx_busy}, 2'b10);
      check("reset_done_err", {tx_done, tx_err}, 2'b00);
      resetN = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i]);
      end

      // Device never clocks: only the timeout ends the transaction.
      sb.push_back('{8'h12, 1'b1, 1'b0});
      start_tx(8'h12, 1'b0, 8'h12);
      n = 0;
      while (!tx_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, TMO);
      check("timeout_err", tx_err, 1'b1);
      repeat (3) @(negedge clk);

      // Reset in the middle of a frame.
      base = done_count;
      start_tx(8'h30, 1'b0, 8'h30);
      device(1'b0, 4, lb, ob);
      check("dat_before_reset", ps2_dat_oe, 1'b1);
      #2 resetN = 1'b0;
      #1;
      check("reset_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      check("reset_mid_ready", tx_ready, 1'b1);
      repeat (3) @(negedge clk);
      #2 resetN = 1'b1;
      repeat (50) @(negedge clk);
      check("no_done_on_reset", done_count, base);
      run_vec(vff);

      // Requests while busy are ignored; the held request goes after tx_ready rises.
      sb.push_back('{8'hF4, 1'b0, 1'b1});
      exp_oe = ~{1'b1, 1'b0, 8'hF4};
      start_tx(8'hF4, 1'b1, 8'hAA);
      device(1'b1, 10, lb, ob);
      check("busy_parity", lb[8], 1'b0);
      check("busy_dat_oe_pattern", ob, exp_oe);
      n = 0;
      while (!tx_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("busy_done_seen", tx_done, 1'b1);
      @(negedge clk);
      check("ready_rises", tx_ready, 1'b1);
      check("no_accept_on_done", ps2_clk_oe, 1'b0);
      @(negedge clk);
      check("accept_after_ready", ps2_clk_oe, 1'b1);
      tx_valid = 1'b0;
      sb.push_back('{8'hAA, 1'b0, 1'b1});
      base = done_count;
      measure_inhibit();
      device(1'b1, 10, lb, ob);
      check("second_parity", lb[8], 1'b1);
      wait_done(base);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
